musteri_sayaci: RTL and testbench

Customer queue counter for two service lines. Takes four raw push-buttons (arrival and served, per line), synchronises and debounces them, and keeps a saturating 2-bit waiting count per line. Its `musteri1` and `musteri2` outputs drive the two-bit comparator's inputs directly, and that comparator drives the red, green and yellow lights. It sits directly upstream of the comparator.

---
 rtl/musteri_sayaci.sv | 121 ++++++++++++
 tb/tb_musteri_sayaci.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/musteri_sayaci.sv
// Customer queue counter for two service lines: four debounced push-buttons
// feed two independent saturating 2-bit waiting counts with error pulses.

module musteri_sayaci_button #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic             d;
    logic             d_prev;
    logic [CNT_W-1:0] cnt;

    // The level is accepted only after DEBOUNCE_CYCLES consecutive mismatching
    // samples; any agreeing sample restarts qualification from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            d      <= 1'b0;
            d_prev <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            s      <= sync1;
            d_prev <= d;
            if (s != d) begin
                if (cnt == LAST) begin
                    d   <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = d & ~d_prev;
endmodule

module musteri_sayaci_line (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] count,
    output logic       hata
);
    // Simultaneous join and leave cancel out; out-of-range requests hold the
    // count and raise a one-cycle error instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            hata  <= 1'b0;
        end else begin
            hata <= 1'b0;
            case ({inc, dec})
                2'b10: begin
                    if (count == 2'd3) hata <= 1'b1;
                    else               count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) hata <= 1'b1;
                    else               count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

module musteri_sayaci #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gel1,
    input  logic       git1,
    input  logic       gel2,
    input  logic       git2,
    output logic [1:0] musteri1,
    output logic [1:0] musteri2,
    output logic       hata1,
    output logic       hata2
);
    logic p_gel1;
    logic p_git1;
    logic p_gel2;
    logic p_git2;

    musteri_sayaci_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gel1 (
        .clk(clk), .rst_n(rst_n), .raw(gel1), .press(p_gel1)
    );
    musteri_sayaci_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_git1 (
        .clk(clk), .rst_n(rst_n), .raw(git1), .press(p_git1)
    );
    musteri_sayaci_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gel2 (
        .clk(clk), .rst_n(rst_n), .raw(gel2), .press(p_gel2)
    );
    musteri_sayaci_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_git2 (
        .clk(clk), .rst_n(rst_n), .raw(git2), .press(p_git2)
    );

    musteri_sayaci_line u_line1 (
        .clk(clk), .rst_n(rst_n), .inc(p_gel1), .dec(p_git1),
        .count(musteri1), .hata(hata1)
    );
    musteri_sayaci_line u_line2 (
        .clk(clk), .rst_n(rst_n), .inc(p_gel2), .dec(p_git2),
        .count(musteri2), .hata(hata2)
    );
endmodule

// File: tb/tb_musteri_sayaci.sv
// Bench for musteri_sayaci: directed scenarios plus random button traffic,
// compared every cycle against a window-based behavioural model.

module tb_musteri_sayaci;
    localparam int DB = 4;
    localparam logic [63:0] WIN = (64'd1 << DB) - 64'd1;

    logic       clk;
    logic       rst_n;
    logic       gel1, git1, gel2, git2;
    logic [1:0] musteri1, musteri2;
    logic       hata1, hata2;

    int vectors;
    int miscompares;
    int hata1_seen;
    int hata2_seen;

    // Model: a button's debounced level flips once its last DB synchronised
    // samples (raw delayed by two edges) all disagree with it.
    bit [63:0] raw_hist [4];
    bit        m_d      [4];
    bit        m_rose   [4];
    int        m_cnt    [2];
    bit        m_hata   [2];

    musteri_sayaci #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n),
        .gel1(gel1), .git1(git1), .gel2(gel2), .git2(git2),
        .musteri1(musteri1), .musteri2(musteri2),
        .hata1(hata1), .hata2(hata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task model_reset();
        for (int b = 0; b < 4; b++) begin
            raw_hist[b] = '0;
            m_d[b]      = 1'b0;
            m_rose[b]   = 1'b0;
        end
        for (int l = 0; l < 2; l++) begin
            m_cnt[l]  = 0;
            m_hata[l] = 1'b0;
        end
    endtask

    task model_edge();
        logic [3:0]  raw;
        logic [63:0] win;
        bit          inc;
        bit          dec;
        raw = {git2, gel2, git1, gel1};
        for (int l = 0; l < 2; l++) begin
            inc       = m_rose[2*l];
            dec       = m_rose[2*l+1];
            m_hata[l] = 1'b0;
            if (inc && !dec) begin
                if (m_cnt[l] == 3) m_hata[l] = 1'b1;
                else               m_cnt[l] = m_cnt[l] + 1;
            end else if (dec && !inc) begin
                if (m_cnt[l] == 0) m_hata[l] = 1'b1;
                else               m_cnt[l] = m_cnt[l] - 1;
            end
        end
        for (int b = 0; b < 4; b++) begin
            raw_hist[b] = {raw_hist[b][62:0], raw[b]};
            win         = (raw_hist[b] >> 2) & WIN;
            m_rose[b]   = 1'b0;
            if (!m_d[b] && win == WIN) begin
                m_d[b]    = 1'b1;
                m_rose[b] = 1'b1;
            end else if (m_d[b] && win == 64'd0) begin
                m_d[b] = 1'b0;
            end
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample 1 ns later.
    task automatic apply_stimulus(input logic [3:0] v);
        {git2, gel2, git1, gel1} = v;
        @(posedge clk);
        model_edge();
        #1;
        check_output("musteri1", musteri1, 2'(m_cnt[0]));
        check_output("musteri2", musteri2, 2'(m_cnt[1]));
        check_output("hata1", {1'b0, hata1}, {1'b0, m_hata[0]});
        check_output("hata2", {1'b0, hata2}, {1'b0, m_hata[1]});
        if (hata1) hata1_seen++;
        if (hata2) hata2_seen++;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("rst_musteri1", musteri1, 2'd0);
        check_output("rst_musteri2", musteri2, 2'd0);
        check_output("rst_hata", {hata1, hata2}, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_btn(input int b);
        logic [3:0] v;
        v = 4'b0001 << b;
        for (int i = 0; i < 10; i++) apply_stimulus(v);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0000);
    endtask

    initial begin
        int          hold [4];
        logic [3:0]  lvl;
        logic [1:0]  exp_seq [5];

        vectors     = 0;
        miscompares = 0;
        hata1_seen  = 0;
        hata2_seen  = 0;
        model_reset();

        // Reset with all buttons held, checked before any clock edge.
        rst_n = 1'b1;
        {git2, gel2, git1, gel1} = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t1_musteri1", musteri1, 2'd0);
        check_output("t1_musteri2", musteri2, 2'd0);
        check_output("t1_hata", {hata1, hata2}, 2'd0);
        @(negedge clk);
        {git2, gel2, git1, gel1} = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) apply_stimulus(4'b0000);

        // Single clean press: count must step exactly on edge DB+3.
        reset_pulse();
        for (int e = 1; e <= 12; e++) begin
            apply_stimulus(4'b0001);
            if (e == 6) check_output("t2_edge6", musteri1, 2'd0);
            if (e == 7) check_output("t2_edge7", musteri1, 2'd1);
        end
        for (int i = 0; i < 12; i++) apply_stimulus(4'b0000);
        check_output("t2_after_release", musteri1, 2'd1);
        check_output("t2_line2", musteri2, 2'd0);

        // Bounce on gel2 faster than qualification.
        hata2_seen = 0;
        for (int i = 0; i < 30; i++) apply_stimulus(((i / 2) % 2 == 1) ? 4'b0100 : 4'b0000);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0000);
        check_output("t3_musteri2", musteri2, 2'd0);
        check_int("t3_hata2", hata2_seen, 0);

        // Saturation up and down.
        reset_pulse();
        hata1_seen = 0;
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd3;
        for (int k = 0; k < 4; k++) begin
            press_btn(0);
            check_output("t4_up", musteri1, exp_seq[k]);
        end
        check_int("t4_hata_up", hata1_seen, 1);
        hata1_seen = 0;
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd1; exp_seq[2] = 2'd0; exp_seq[3] = 2'd0; exp_seq[4] = 2'd0;
        for (int k = 0; k < 5; k++) begin
            press_btn(1);
            check_output("t4_down", musteri1, exp_seq[k]);
        end
        check_int("t4_hata_down", hata1_seen, 2);

        // Simultaneous join+leave on line 1 while line 2 joins.
        press_btn(0);
        press_btn(0);
        hata1_seen = 0;
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0111);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0000);
        check_output("t5_musteri1", musteri1, 2'd2);
        check_output("t5_musteri2", musteri2, 2'd1);
        check_int("t5_hata1", hata1_seen, 0);

        // Reset in the middle of gel2 qualification, button held through release.
        press_btn(0);
        check_output("t6_full", musteri1, 2'd3);
        for (int e = 1; e <= 4; e++) apply_stimulus(4'b0100);
        #2;
        reset_pulse();
        for (int e = 1; e <= 10; e++) begin
            apply_stimulus(4'b0100);
            if (e == 6) check_output("t6_edge6", musteri2, 2'd0);
            if (e == 7) check_output("t6_edge7", musteri2, 2'd1);
        end
        check_output("t6_musteri1", musteri1, 2'd0);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0000);

        // Random traffic with random hold lengths and occasional reset.
        for (int b = 0; b < 4; b++) hold[b] = 0;
        lvl = 4'b0000;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = $urandom_range(0, 1) == 1;
                    hold[b] = $urandom_range(1, 14);
                end
                hold[b]--;
            end
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else apply_stimulus(lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
